muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter ITER, default 32, the number of CALC iterations; only 32 is supported.
REQ-002 SHALL have input gclk, 1 bit: clock; all state changes on its rising edge.
REQ-003 SHALL have input reset, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have input start, 1 bit: request a new operation.
REQ-005 SHALL have input op, 2 bits: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 SHALL have inputs a and b, 32 bits each: rs and rt operands, sampled only on the accepting edge.
REQ-007 SHALL have input kill, 1 bit: abort the operation in flight.
REQ-008 SHALL have output busy, 1 bit: operation in progress; the core stalls on it.
REQ-009 SHALL have output done, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have outputs hi and lo, 32 bits each: architectural HI and LO registers, read by MFHI and MFLO.

Function
REQ-011 SHALL implement an FSM with states IDLE, CALC, FIX and DONE.
REQ-012 SHALL accept start only in IDLE or DONE; on the accepting edge it latches op, a and b, clears the 5-bit iteration counter and enters CALC.
REQ-013 SHALL ignore start while in CALC or FIX; no queuing.
REQ-014 SHALL perform one shift-add multiply step or one restoring-divide step per CALC cycle, on operand magnitudes for signed ops and raw values for unsigned ops.
REQ-015 SHALL leave CALC for FIX on the edge where the counter equals 31 (32 CALC cycles); the counter does not wrap otherwise.
REQ-016 SHALL apply sign correction in FIX:
- MULT: negate the 64-bit product when the operand signs differ.
- DIV: negate the quotient when the signs differ; the remainder takes the sign of a.
REQ-017 SHALL write HI/LO on the FIX->DONE edge: multiply gives hi=product[63:32], lo=product[31:0]; divide gives hi=remainder, lo=quotient.
REQ-018 SHALL use fixed latency: accepting edge E0, done=1 during the cycle after edge E33, back in IDLE at E34 unless restarted.
REQ-019 SHALL drive busy=1 in CALC and FIX only, and done=1 in DONE only.
REQ-020 SHALL, on divide by zero, produce lo=0xFFFFFFFF and hi=a with the same latency, for both DIV and DIVU.
REQ-021 SHALL, for DIV of 0x80000000 by 0xFFFFFFFF, produce lo=0x80000000 and hi=0 with no trap.
REQ-022 SHALL, when kill=1, enter IDLE on the next edge from any state and leave hi/lo unchanged unless the FSM is in FIX, where the HI/LO write is suppressed; kill has priority over start.
REQ-023 SHALL keep hi and lo stable except on the FIX->DONE edge.

Reset
REQ-024 SHALL, on reset asserted at any time including mid-operation, immediately force state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0 and discard the operands.
REQ-025 SHALL accept start on the first rising gclk edge after reset deasserts.

Structure
REQ-026 SHALL place the op encodings, the FSM state encoding and ITER in shared package muldiv_pkg.
REQ-027 SHALL implement the per-iteration combinational step (add/shift, or subtract/compare/restore) as sub-module muldiv_step, instantiated once.
REQ-028 SHALL contain only gclk-domain flops with no internal clock gating; total RTL is 120-400 lines.

Verification
REQ-029 SHALL cover MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done pulse in the cycle after E33, busy high 33 cycles.
REQ-030 SHALL cover MULT a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-031 SHALL cover DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064.
REQ-032 SHALL cover kill=1 pulsed 10 cycles after start, with hi/lo preloaded to 42/7 -> IDLE next edge, hi/lo stay 42/7, no done pulse.
REQ-033 SHALL cover start held during DONE with a new MULTU 6*7 -> accepted at that edge, second done 34 cycles later, lo=42; start asserted during CALC -> ignored.
REQ-034 SHALL cover reset asserted mid-CALC -> busy=0, hi=lo=0 immediately, with no gclk edge required.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the sequential multiply/divide unit: op codes, FSM states
// and the iteration count.
package muldiv_pkg;

  localparam int ITER = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // Magnitude for signed ops, raw value for unsigned ones.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring divide
// on a 64-bit accumulator ({upper, lower}).
module muldiv_step (
  input  logic        is_div,
  input  logic [63:0] acc_in,
  input  logic [31:0] operand,
  output logic [63:0] acc_out
);

  logic [32:0] sum;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        ge;

  always_comb begin
    // Multiply: conditionally add the multiplicand to the upper half, then shift right.
    sum     = {1'b0, acc_in[63:32]} + (acc_in[0] ? {1'b0, operand} : 33'd0);
    // Divide: bring the next dividend bit into the partial remainder, trial-subtract.
    shifted = acc_in[63:31];
    diff    = shifted - {1'b0, operand};
    ge      = (shifted >= {1'b0, operand});
    if (is_div)
      acc_out = {(ge ? diff[31:0] : shifted[31:0]), acc_in[30:0], ge};
    else
      acc_out = {sum, acc_in[31:1]};
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit: 32 CALC steps, one FIX step for sign
// correction, then HI/LO are written and a one-cycle done pulse is raised.
module muldiv_seq #(
  parameter int ITER = muldiv_pkg::ITER
) (
  input  logic        gclk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        kill,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  import muldiv_pkg::*;

  state_t      state_reg;
  op_t         op_reg;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [63:0] acc_reg;
  logic [4:0]  cnt_reg;
  logic        busy_reg;
  logic        done_reg;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;

  logic        is_signed;
  logic        is_div;
  logic [31:0] operand;
  logic [63:0] acc_next;
  logic [31:0] hi_next;
  logic [31:0] lo_next;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        neg;

  assign is_signed = ~op_reg[0];
  assign is_div    = op_reg[1];
  assign operand   = mag32(b_reg, is_signed);

  muldiv_step u_step (
    .is_div  (is_div),
    .acc_in  (acc_reg),
    .operand (operand),
    .acc_out (acc_next)
  );

  // Sign correction applied to the magnitude result while in FIX.
  always_comb begin
    neg     = is_signed & (a_reg[31] ^ b_reg[31]);
    prod    = neg ? (~acc_reg + 64'd1) : acc_reg;
    quo     = neg ? (~acc_reg[31:0] + 32'd1) : acc_reg[31:0];
    rem     = (is_signed && a_reg[31]) ? (~acc_reg[63:32] + 32'd1) : acc_reg[63:32];
    hi_next = prod[63:32];
    lo_next = prod[31:0];
    if (is_div) begin
      if (b_reg == 32'd0) begin
        hi_next = a_reg;
        lo_next = 32'hFFFF_FFFF;
      end else begin
        hi_next = rem;
        lo_next = quo;
      end
    end
  end

  always_ff @(posedge gclk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      op_reg    <= OP_MULT;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else if (kill) begin
      state_reg <= ST_IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          done_reg <= 1'b0;
          if (start) begin
            op_reg    <= op_t'(op);
            a_reg     <= a;
            b_reg     <= b;
            acc_reg   <= {32'd0, mag32(a, ~op[0])};
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= ST_CALC;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_CALC: begin
          acc_reg <= acc_next;
          if (cnt_reg == 5'(ITER - 1)) begin
            state_reg <= ST_FIX;
          end else begin
            cnt_reg <= cnt_reg + 5'd1;
          end
        end
        ST_FIX: begin
          hi_reg    <= hi_next;
          lo_reg    <= lo_next;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= ST_DONE;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected {hi,lo} pushed at issue, popped and
// compared by a monitor on each done pulse.
module tb_muldiv_seq;

  logic        gclk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] sb_q[$];

  muldiv_seq #(.ITER(32)) dut (
    .gclk  (gclk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .kill  (kill),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  // Reference: plain 64-bit arithmetic on the architectural definitions.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, sq, sr;
    logic [63:0] ux, uy, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      2'b00: r = 64'(sx * sy);
      2'b01: r = ux * uy;
      2'b10: begin
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else begin
          sq = sx / sy;
          sr = sx % sy;
          r = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else r = {32'(ux % uy), 32'(ux / uy)};
      end
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge gclk) begin
    if (!reset && done === 1'b1) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: got hi=%h lo=%h with no operation outstanding", hi, lo);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        if ({hi, lo} !== e) begin
          n_fail++;
          $display("FAIL result: got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, e[63:32], e[31:0]);
        end else begin
          $display("[TB] done hi=%h lo=%h ok", hi, lo);
        end
      end
    end
  end

  // Waits from just after the accepting edge until done, checking the busy window.
  task automatic wait_done(input string tag);
    int busy_cnt = 0;
    int t = 0;
    while (busy === 1'b1 && t < 40) begin
      busy_cnt++;
      t++;
      @(posedge gclk);
      #1;
    end
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
    chk({tag, "_done_pulse"}, {63'd0, done}, 64'd1);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge gclk);
    op = o; a = x; b = y; start = 1'b1;
    sb_q.push_back(model(o, x, y));
    $display("[TB] issue op=%0d a=%h b=%h", o, x, y);
    @(posedge gclk);
    #1 start = 1'b0;
    wait_done("op");
  endtask

  task automatic issue_no_push(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge gclk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge gclk);
    #1 start = 1'b0;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int t;
    reset = 1'b1; start = 1'b0; kill = 1'b0; op = 2'b00; a = '0; b = '0;
    #23;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op(2'b11, 32'd100, 32'd0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b10, 32'hFFFF_FF00, 32'd0);

    // Kill during CALC: preload hi/lo = 42/7 (742 / 100), then abort.
    run_op(2'b11, 32'd742, 32'd100);
    issue_no_push(2'b01, 32'd1234, 32'd5678);
    repeat (9) @(posedge gclk);
    @(negedge gclk) kill = 1'b1;
    @(posedge gclk);
    #1 kill = 1'b0;
    chk("kill_busy", {63'd0, busy}, 64'd0);
    repeat (40) @(posedge gclk);
    #1 chk("kill_hilo", {hi, lo}, {32'd42, 32'd7});

    // Kill while in FIX suppresses the HI/LO write.
    issue_no_push(2'b00, 32'd99, 32'd99);
    repeat (32) @(posedge gclk);
    #1 kill = 1'b1;
    @(posedge gclk);
    #1 kill = 1'b0;
    chk("kill_fix_busy", {63'd0, busy}, 64'd0);
    repeat (5) @(posedge gclk);
    #1 chk("kill_fix_hilo", {hi, lo}, {32'd42, 32'd7});

    // Start during CALC ignored; start held in DONE accepted.
    @(negedge gclk);
    op = 2'b01; a = 32'd1000; b = 32'd3000; start = 1'b1;
    sb_q.push_back(model(2'b01, 32'd1000, 32'd3000));
    @(posedge gclk);
    #1 start = 1'b0;
    repeat (5) @(posedge gclk);
    @(negedge gclk);
    op = 2'b00; a = 32'd123; b = 32'd456; start = 1'b1;
    @(posedge gclk);
    #1 start = 1'b0;
    t = 0;
    do begin
      @(negedge gclk);
      t++;
    end while (done !== 1'b1 && t < 50);
    chk("b2b_first_done", {63'd0, done}, 64'd1);
    op = 2'b01; a = 32'd6; b = 32'd7; start = 1'b1;
    sb_q.push_back(64'd42);
    @(posedge gclk);
    #1 start = 1'b0;
    chk("b2b_accept_busy", {63'd0, busy}, 64'd1);
    wait_done("b2b");
    #1 chk("b2b_lo", {32'd0, lo}, 64'd42);

    // Asynchronous reset mid-CALC, then start on the first edge after release.
    issue_no_push(2'b11, 32'd5000, 32'd3);
    repeat (10) @(posedge gclk);
    #2 reset = 1'b1;
    #1;
    chk("amid_reset_busy", {63'd0, busy}, 64'd0);
    chk("amid_reset_hilo", {hi, lo}, 64'd0);
    op = 2'b00; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    sb_q.push_back(model(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
    #2 reset = 1'b0;
    @(posedge gclk);
    #1 start = 1'b0;
    chk("post_reset_accept", {63'd0, busy}, 64'd1);
    wait_done("post_reset");

    for (int i = 0; i < 30; i++) begin
      run_op(2'($urandom_range(0, 3)), rnd_val(), rnd_val());
    end

    repeat (5) @(posedge gclk);
    #1 chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
